// File: rtl/eth_wb_slave_mem_pkg.sv
// eth_wb_slave_pkg: shared state encoding, widths and byte-lane mask helper
// for the eth_wb_slave_mem Wishbone target.
`default_nettype none

package eth_wb_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int WAIT_W = 4;
  localparam int STAT_W = 16;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_wb_slave_mem_if.sv
// eth_wb_slave_mem_if: Wishbone classic bus bundle between host master and
// the memory target. Rev 1.0
`default_nettype none

interface eth_wb_slave_mem_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

`default_nettype wire

// File: rtl/eth_wb_slave_mem_ram.sv
// eth_wb_slave_ram: DEPTH x 32 single-port RAM, per-byte write enables and a
// registered read port. Contents are never reset. Rev 1.0
`default_nettype none

module eth_wb_slave_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  input  logic          i_re,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/eth_wb_slave_mem.sv
// eth_wb_slave_mem: Wishbone classic memory target with programmable wait
// states and error response. Optional macro: ETH_WB_SLAVE_MEM_STATS_EN. Rev 1.0
`default_nettype none

module eth_wb_slave_mem
  import eth_wb_slave_pkg::*;
#(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          Tp       = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  eth_wb_slave_mem_if.slave wb,
  input  logic [WAIT_W-1:0] wait_cfg_i
`ifdef ETH_WB_SLAVE_MEM_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_wr_o,
  output logic [STAT_W-1:0] stat_rd_o,
  output logic [STAT_W-1:0] stat_err_o
`endif
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  // Tp only matters to behavioural models elsewhere in the codebase.
  logic w_unused_tp;
  assign w_unused_tp = ^Tp;

  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_cnt;
  logic [31:0]       r_adr, r_dat;
  logic [3:0]        r_sel;
  logic              r_we, r_ack, r_err, r_rd;

  logic [31:0] w_adr, w_dat, w_off, w_rdata;
  logic [3:0]  w_sel;
  logic        w_we, w_req, w_valid, w_enter;

  // At the request edge the live bus is used; afterwards the latched copy.
  assign w_adr   = (r_state == ST_IDLE) ? wb.wb_adr_i : r_adr;
  assign w_dat   = (r_state == ST_IDLE) ? wb.wb_dat_i : r_dat;
  assign w_sel   = (r_state == ST_IDLE) ? wb.wb_sel_i : r_sel;
  assign w_we    = (r_state == ST_IDLE) ? wb.wb_we_i  : r_we;
  assign w_req   = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_off   = w_adr - BASE_ADR;
  assign w_valid = (w_off < SPAN) && (w_adr[1:0] == 2'b00) && (w_sel != 4'h0);

  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (wait_cfg_i == '0) begin
            w_next  = ST_RESP;
            w_enter = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wb.wb_cyc_i) begin
          w_next = ST_IDLE;
        end else if (r_cnt == WAIT_W'(1)) begin
          w_next  = ST_RESP;
          w_enter = 1'b1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_req) begin
        r_adr <= wb.wb_adr_i;
        r_dat <= wb.wb_dat_i;
        r_sel <= wb.wb_sel_i;
        r_we  <= wb.wb_we_i;
        r_cnt <= wait_cfg_i;
      end else if (w_next == ST_WAIT) begin
        r_cnt <= r_cnt - WAIT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      r_ack <= w_enter & w_valid;
      r_err <= w_enter & ~w_valid;
      r_rd  <= w_enter & w_valid & ~w_we;
    end
  end

  logic       w_ram_wr, w_ram_re;
  logic [3:0] w_be;

  // Gating with reset keeps a reset on the commit edge from writing.
  assign w_ram_wr = w_enter & w_valid & w_we & ~wb_rst_i;
  assign w_ram_re = w_enter & w_valid & ~w_we & ~wb_rst_i;
  assign w_be     = w_sel & {4{w_ram_wr}};

  eth_wb_slave_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (wb_clk_i),
    .i_addr  (w_off[AW+1:2]),
    .i_wdata (w_dat),
    .i_be    (w_be),
    .i_re    (w_ram_re),
    .o_rdata (w_rdata)
  );

  assign wb.wb_dat_o = r_rd ? (w_rdata & lane_mask(r_sel)) : 32'h0;
  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;

`ifdef ETH_WB_SLAVE_MEM_STATS_EN
  logic [STAT_W-1:0] r_stat_wr, r_stat_rd, r_stat_err;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_stat_wr  <= '0;
      r_stat_rd  <= '0;
      r_stat_err <= '0;
    end else if (w_enter) begin
      if (w_valid && w_we && r_stat_wr != '1)   r_stat_wr  <= r_stat_wr + 1'b1;
      if (w_valid && !w_we && r_stat_rd != '1)  r_stat_rd  <= r_stat_rd + 1'b1;
      if (!w_valid && r_stat_err != '1)         r_stat_err <= r_stat_err + 1'b1;
    end
  end

  assign stat_wr_o  = r_stat_wr;
  assign stat_rd_o  = r_stat_rd;
  assign stat_err_o = r_stat_err;
`endif

endmodule

`default_nettype wire

// File: doc/eth_wb_slave_mem.md
Name: eth_wb_slave_mem

Overview:
- Synthesizable Wishbone classic slave: a word-addressed, byte-laned memory with programmable wait states and error response.
- Sits directly downstream of the Ethernet testbench Wishbone host master; consumes its single read/write cycles as a bus target.
- Gives the host a deterministic target for checking ack/err timing, byte selects and read-back before the MAC register file is attached.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of 2, range 2..4096.
- BASE_ADR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- Tp, 1, delay on register assignments for simulation, matching the codebase convention.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lane enables; bit n selects bits 8n+7:8n.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wait_cfg_i  in  4  wait states inserted before the response, 0..15.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  normal termination, registered.
- wb_err_o  out  1  error termination, registered.

Behaviour:
- Reset (wb_rst_i=1 at an edge): state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wait counter=0. Memory contents are not reset.
- Reset mid-transaction: the transaction is dropped, no write is committed, and no ack/err is issued.
- States:
  - IDLE: at edge E0 with cyc_i&stb_i=1, latch adr, dat, sel, we and N=wait_cfg_i. Go to WAIT if N>0, else go to RESP.
  - WAIT: decrement counter each edge; go to RESP when the counter reaches 0. If cyc_i=0 at any edge, abort to IDLE with no write and no response.
  - RESP: ack_o or err_o is high for exactly this one cycle; next state is always IDLE. stb_i is ignored at the RESP→IDLE edge, so a master holding stb one edge past ack does not start a second transaction.
- Timing:
  - ack_o/err_o rises at edge E0+N and falls at E0+N+1.
  - Latency from the request edge to the response becoming visible is N+1 cycles.
  - Minimum spacing between back-to-back requests is 2 cycles.
- Decode:
  - Request is valid when (adr-BASE_ADR) < DEPTH*4, adr[1:0]=0, and sel≠0.
  - Word index = (adr-BASE_ADR)>>2, log2(DEPTH) bits.
  - Invalid request → err_o instead of ack_o; no write; wb_dat_o=0.
- Write: committed at the edge entering RESP; only lanes with sel=1 are updated, other bytes are unchanged.
- Read:
  - wb_dat_o loaded at the edge entering RESP with the memory word.
  - Lanes with sel=0 read as 0x00.
  - wb_dat_o returns to 0 at the edge leaving RESP.
- ack_o and err_o are never high together and are never high outside RESP.

Optional Feature:
- Macro: ETH_WB_SLAVE_MEM_STATS_EN.
- With the macro defined:
  - Extra output ports stat_wr_o[15:0], stat_rd_o[15:0], stat_err_o[15:0].
  - Each increments at the RESP edge for a completed write-ack, read-ack, or err respectively.
  - Counters saturate at 16'hFFFF, clear on reset, and do not count aborts.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package eth_wb_slave_pkg:
  - state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2;
  - WAIT_W=4;
  - STAT_W=16;
  - the byte-lane mask helper constant.
- Sub-module eth_wb_slave_ram:
  - DEPTH x 32 single-port RAM with 4 byte write enables and a registered read port;
  - the FSM/decode stays in the top module.

Test Plan:
- Reset, then write 0x8 sel=F data=0xDEADBEEF with wait_cfg=0, then read 0x8 → ack 1 cycle after each request edge; read data 0xDEADBEEF; err_o stays 0.
- wait_cfg=5, write 0x10 data=0x11223344 → ack_o rises at E0+5 and is high for exactly 1 cycle; read with sel=4'b0101 → 0x00220044.
- Partial write 0x10 sel=4'b0010 data=0xAAAA_BBBB, then full read → 0x1122BB44.
- Out-of-range read at BASE_ADR+DEPTH*4, misaligned write 0x13, and sel=0 write → err_o 1 cycle each, ack_o 0, wb_dat_o=0, memory unchanged.
- wait_cfg=8 write to 0x20; drop cyc at E0+3; assert reset mid-WAIT on a second write → no ack/err, 0x20 reads as its prior value, outputs 0 after reset.
- With ETH_WB_SLAVE_MEM_STATS_EN: 3 writes, 2 reads, 1 err, 1 abort → stat_wr=3, stat_rd=2, stat_err=1; preload near saturation to check the counters hold at 16'hFFFF.
